// File: rtl/dcache_wb_buffer.sv
// dcache_wb_buffer
//   Write-back buffer between the d_cache physical-memory side and the memory
//   arbiter data port. Dirty-line evictions land in a small circular FIFO and
//   are acknowledged in one cycle. Read requests that hit a buffered line are
//   served from the buffer. Buffered lines drain to the arbiter whenever the
//   cache has no request pending. Read misses pass straight through to memory.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   cache_*         d_cache side: address, evicted line, read/write strobes,
//                   fill data and a 1-cycle completion pulse
//   mem_*           arbiter side: address, line out, read/write strobes,
//                   line in and completion pulse
//   stat_*          (only with DCACHE_WB_STATS_EN) wrapping 32-bit counters of
//                   read hits, write coalesces and full-buffer stalls
//
// Configuration
//   DCACHE_WB_STATS_EN  when defined, adds the stat_* outputs and counters.
//                       Buffer behaviour is the same either way.

module dcache_wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cache_address,
  input  logic [LINE_W-1:0] cache_wdata,
  input  logic              cache_read,
  input  logic              cache_write,
  output logic [LINE_W-1:0] cache_rdata,
  output logic              cache_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
`ifdef DCACHE_WB_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_coalesce,
  output logic [31:0]       stat_full_stalls
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - 5;

  typedef enum logic [2:0] {IDLE, ACK, MISS, DRAIN, FULL_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [DEPTH];
  logic [TAG_W-1:0]    tag_d  [DEPTH];
  logic [LINE_W-1:0]   line_q [DEPTH];
  logic [LINE_W-1:0]   line_d [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;

  logic [TAG_W-1:0]    req_tag;
  logic                hit;
  logic [PTR_W-1:0]    hit_idx;
  logic                full;

  // Tag CAM over all valid entries. Coalescing keeps tags unique, so at most
  // one entry can match.
  always_comb begin
    req_tag = cache_address[ADDR_W-1:5];
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
    full = (count_q == CNT_W'(DEPTH));
  end

  // Next-state logic. Requests are only evaluated in IDLE; a drain in flight
  // always completes before the pending request is looked at again.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    line_d  = line_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (cache_write) begin
          if (hit) begin
            line_d[hit_idx] = cache_wdata;
            state_d         = ACK;
          end else if (!full) begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = req_tag;
            line_d[tail_q]  = cache_wdata;
            tail_d          = tail_q + PTR_W'(1);
            count_d         = count_q + CNT_W'(1);
            state_d         = ACK;
          end else begin
            state_d = FULL_DRAIN;
          end
        end else if (cache_read) begin
          if (hit) begin
            rdata_d = line_q[hit_idx];
            state_d = ACK;
          end else begin
            state_d = MISS;
          end
        end else if (count_q != '0) begin
          state_d = DRAIN;
        end
      end

      ACK: state_d = IDLE;

      MISS: begin
        if (mem_resp) begin
          rdata_d = mem_rdata;
          state_d = ACK;
        end
      end

      DRAIN, FULL_DRAIN: begin
        if (mem_resp) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + PTR_W'(1);
          count_d         = count_q - CNT_W'(1);
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= tag_d[i];
        line_q[i] <= line_d[i];
      end
    end
  end

  // Arbiter-side outputs decode straight from the state, so they drop to zero
  // as soon as reset forces IDLE. The head entry cannot change during a drain.
  always_comb begin
    cache_rdata = rdata_q;
    cache_resp  = (state_q == ACK);
    mem_read    = (state_q == MISS);
    mem_write   = (state_q == DRAIN) || (state_q == FULL_DRAIN);
    mem_address = '0;
    mem_wdata   = '0;
    if (state_q == MISS) begin
      mem_address = cache_address;
    end else if (mem_write) begin
      mem_address = {tag_q[head_q], 5'b0};
      mem_wdata   = line_q[head_q];
    end
  end

`ifdef DCACHE_WB_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] coalesce_q, coalesce_d;
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    hits_d     = hits_q;
    coalesce_d = coalesce_q;
    stalls_d   = stalls_q;
    if (state_q == IDLE) begin
      if (cache_write) begin
        if (hit) coalesce_d = coalesce_q + 32'd1;
        else if (full) stalls_d = stalls_q + 32'd1;
      end else if (cache_read && hit) begin
        hits_d = hits_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q     <= '0;
      coalesce_q <= '0;
      stalls_q   <= '0;
    end else begin
      hits_q     <= hits_d;
      coalesce_q <= coalesce_d;
      stalls_q   <= stalls_d;
    end
  end

  assign stat_hits        = hits_q;
  assign stat_coalesce    = coalesce_q;
  assign stat_full_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Testbench for dcache_wb_buffer. A transaction-level model (ordered list of
// buffered lines plus the latest value written to every line address) checks
// the DUT on every cycle; directed scenarios add hand-computed expectations.

module tb_dcache_wb_buffer;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cache_address;
  logic [255:0] cache_wdata;
  logic         cache_read;
  logic         cache_write;
  logic [255:0] cache_rdata;
  logic         cache_resp;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_rdata;
  logic         mem_resp;
`ifdef DCACHE_WB_STATS_EN
  logic [31:0]  stat_hits, stat_coalesce, stat_full_stalls;
`endif

  dcache_wb_buffer dut (
    .clk(clk), .rst(rst),
    .cache_address(cache_address), .cache_wdata(cache_wdata),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_rdata(cache_rdata), .cache_resp(cache_resp),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
`ifdef DCACHE_WB_STATS_EN
    , .stat_hits(stat_hits), .stat_coalesce(stat_coalesce),
    .stat_full_stalls(stat_full_stalls)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int failed = 0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [26:0]  tag;
    logic [255:0] line;
  } ent_t;

  ent_t         mq[$];
  logic [255:0] golden[logic [26:0]];
  logic [255:0] mem_model[logic [26:0]];

  function automatic logic [255:0] defaultLine(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  function automatic logic [255:0] expectRead(input logic [26:0] t);
    if (golden.exists(t)) return golden[t];
    return defaultLine({t, 5'b0});
  endfunction

  function automatic bit inQueue(input logic [26:0] t);
    foreach (mq[i]) if (mq[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void modelWrite(input logic [26:0] t, input logic [255:0] l);
    bit found = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].tag == t) begin
        mq[i].line = l;
        found = 1'b1;
      end
    end
    if (!found) mq.push_back('{tag: t, line: l});
    golden[t] = l;
  endfunction

  // ---------------- arbiter ----------------
  bit arb_hold = 1'b0;
  int arb_delay = 2;
  int arb_cnt = 0;

  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || mem_resp) begin
        mem_resp = 1'b0;
        arb_cnt  = 0;
      end else if ((mem_read || mem_write) && !arb_hold) begin
        arb_cnt++;
        if (arb_cnt >= arb_delay) begin
          mem_resp = 1'b1;
          if (mem_write) begin
            mem_model[mem_address[31:5]] = mem_wdata;
          end else if (mem_model.exists(mem_address[31:5])) begin
            mem_rdata = mem_model[mem_address[31:5]];
          end else begin
            mem_rdata = defaultLine({mem_address[31:5], 5'b0});
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic         prev_req_read = 0, prev_req_write = 0, prev_resp = 0;
  logic [26:0]  prev_tag = '0;
  logic         prev_mem_read = 0, prev_mem_write = 0, prev_mem_resp = 0;
  logic [31:0]  prev_mem_address = '0;
  logic [255:0] prev_mem_wdata = '0;
  int           mem_read_cycles = 0, mem_write_cycles = 0, drain_count = 0;
  logic [31:0]  last_drain_addr = '0;
  logic [255:0] last_drain_data = '0;
  int           last_write_resp_cyc = 0, last_read_resp_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_req_read = 0; prev_req_write = 0; prev_resp = 0;
      prev_mem_read = 0; prev_mem_write = 0; prev_mem_resp = 0;
      mq.delete();
      golden = mem_model;
    end else begin
      checkOutput("mem_rw_exclusive", 256'(mem_read & mem_write), 256'(0));
      if (mem_read) begin
        mem_read_cycles++;
        checkOutput("miss_address", 256'(mem_address), 256'(cache_address));
      end
      if (mem_write) mem_write_cycles++;

      if ((mem_read || mem_write) && !prev_mem_read && !prev_mem_write) begin
        if (mem_write)
          checkOutput("drain_start_allowed",
                      256'((!prev_req_read && !prev_req_write) ||
                           (prev_req_write && !inQueue(prev_tag) && mq.size() == DEPTH)),
                      256'(1));
        else
          checkOutput("miss_start_allowed",
                      256'(prev_req_read && !prev_req_write && !inQueue(prev_tag)),
                      256'(1));
      end

      if ((prev_mem_read || prev_mem_write) && !prev_mem_resp) begin
        checkOutput("mem_read_stable", 256'(mem_read), 256'(prev_mem_read));
        checkOutput("mem_write_stable", 256'(mem_write), 256'(prev_mem_write));
        checkOutput("mem_address_stable", 256'(mem_address), 256'(prev_mem_address));
        if (mem_write) checkOutput("mem_wdata_stable", mem_wdata, prev_mem_wdata);
      end

      if (prev_mem_resp && (prev_mem_read || prev_mem_write))
        checkOutput("mem_drop_after_resp", 256'(mem_read | mem_write), 256'(0));

      if (mem_resp && mem_write) begin
        checkOutput("drain_has_entry", 256'(mq.size() > 0), 256'(1));
        if (mq.size() > 0) begin
          checkOutput("drain_address", 256'(mem_address), 256'({mq[0].tag, 5'b0}));
          checkOutput("drain_data", mem_wdata, mq[0].line);
          void'(mq.pop_front());
        end
        drain_count++;
        last_drain_addr     = mem_address;
        last_drain_data     = mem_wdata;
        last_write_resp_cyc = cyc;
      end
      if (mem_resp && mem_read) last_read_resp_cyc = cyc;

      if (cache_resp) begin
        checkOutput("resp_single_pulse", 256'(prev_resp), 256'(0));
        if (cache_write) begin
          modelWrite(cache_address[31:5], cache_wdata);
          checkOutput("buffer_occupancy", 256'(mq.size() <= DEPTH), 256'(1));
        end else if (cache_read) begin
          checkOutput("read_data", cache_rdata, expectRead(cache_address[31:5]));
        end
      end

      prev_req_read    = cache_read;
      prev_req_write   = cache_write;
      prev_tag         = cache_address[31:5];
      prev_resp        = cache_resp;
      prev_mem_read    = mem_read;
      prev_mem_write   = mem_write;
      prev_mem_resp    = mem_resp;
      prev_mem_address = mem_address;
      prev_mem_wdata   = mem_wdata;
    end
  end

  // ---------------- stimulus ----------------
  // Drives one request from the current cycle and waits for cache_resp; keeps
  // it held through the ACK cycle, then drops it so the next request (if any)
  // is presented in the following IDLE cycle.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [255:0] data,
                               input int budget, output int lat, output int resp_cyc);
    cache_address = addr;
    cache_wdata   = data;
    cache_write   = wr;
    cache_read    = !wr;
    lat = 0;
    resp_cyc = 0;
    while (!cache_resp && lat < budget) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!cache_resp) begin
      checkOutput("resp_timeout", 256'(cache_resp), 256'(1));
    end else begin
      resp_cyc = cyc;
      @(posedge clk);
      #1;
    end
    cache_read  = 1'b0;
    cache_write = 1'b0;
  endtask

  task automatic waitDrained(input int budget);
    int k = 0;
    while ((mq.size() != 0 || mem_write) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("drain_complete", 256'(mq.size() == 0 && !mem_write), 256'(1));
  endtask

  localparam logic [255:0] LINE_A = {8{32'hAAAA_0001}};
  localparam logic [255:0] LINE_B = {8{32'hBBBB_0002}};
  localparam logic [255:0] LINE_D = {8{32'hDDDD_0004}};

  initial begin
    int lat, rc, base, snap, k;
    bit fifth_done;
    logic [255:0] ln;

    rst = 1'b1;
    cache_address = '0;
    cache_wdata   = '0;
    cache_read    = 1'b0;
    cache_write   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cache_resp", 256'(cache_resp), 256'(0));
    checkOutput("reset_cache_rdata", cache_rdata, 256'(0));
    checkOutput("reset_mem_read", 256'(mem_read), 256'(0));
    checkOutput("reset_mem_write", 256'(mem_write), 256'(0));
    checkOutput("reset_mem_address", 256'(mem_address), 256'(0));
    checkOutput("reset_mem_wdata", mem_wdata, 256'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: single write, drained once requests go idle
    base = drain_count;
    snap = mem_write_cycles;
    applyStimulus(1'b1, 32'h0000_1000, LINE_A, 20, lat, rc);
    checkOutput("t1_write_latency", 256'(lat), 256'(1));
    checkOutput("t1_no_drain_while_busy", 256'(mem_write_cycles), 256'(snap));
    waitDrained(50);
    checkOutput("t1_drain_count", 256'(drain_count - base), 256'(1));
    checkOutput("t1_drain_addr", 256'(last_drain_addr), 256'(32'h0000_1000));
    checkOutput("t1_drain_data", last_drain_data, LINE_A);

    // 2: read hit served from the buffer
    snap = mem_read_cycles;
    applyStimulus(1'b1, 32'h0000_1000, LINE_A, 20, lat, rc);
    applyStimulus(1'b0, 32'h0000_1000, '0, 20, lat, rc);
    checkOutput("t2_hit_latency", 256'(lat), 256'(1));
    checkOutput("t2_hit_data", cache_rdata, LINE_A);
    checkOutput("t2_no_mem_read", 256'(mem_read_cycles), 256'(snap));
    waitDrained(50);

    // 3: coalescing write
    base = drain_count;
    applyStimulus(1'b1, 32'h0000_1000, LINE_A, 20, lat, rc);
    applyStimulus(1'b1, 32'h0000_1000, LINE_B, 20, lat, rc);
    checkOutput("t3_coalesce_latency", 256'(lat), 256'(1));
    waitDrained(50);
    checkOutput("t3_drain_count", 256'(drain_count - base), 256'(1));
    checkOutput("t3_drain_data", last_drain_data, LINE_B);

    // 4: full buffer with the arbiter stalled
    base = drain_count;
    arb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(i * 32), {8{32'h4000_0000 + 32'(i)}}, 20, lat, rc);
      checkOutput("t4_fill_latency", 256'(lat), 256'(1));
    end
    fifth_done = 1'b0;
    fork
      begin
        applyStimulus(1'b1, 32'h0000_0080, {8{32'h4000_0004}}, 200, lat, rc);
        fifth_done = 1'b1;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t4_fifth_waiting", 256'(fifth_done), 256'(0));
        checkOutput("t4_full_drain_write", 256'(mem_write), 256'(1));
        checkOutput("t4_full_drain_addr", 256'(mem_address), 256'(0));
        ln = {8{32'h4000_0000}};
        checkOutput("t4_full_drain_data", mem_wdata, ln);
        arb_delay = 1;
        arb_hold  = 1'b0;
      end
    join
    checkOutput("t4_first_drain_addr", 256'(last_drain_addr), 256'(0));
    checkOutput("t4_fifth_resp_timing", 256'(rc), 256'(last_write_resp_cyc + 2));
    waitDrained(100);
    checkOutput("t4_total_drains", 256'(drain_count - base), 256'(5));

    // 5: read miss with a slow arbiter
    arb_delay = 10;
    snap = mem_read_cycles;
    applyStimulus(1'b0, 32'h0000_2000, '0, 50, lat, rc);
    checkOutput("t5_mem_read_cycles", 256'(mem_read_cycles - snap), 256'(10));
    checkOutput("t5_resp_timing", 256'(rc), 256'(last_read_resp_cyc + 1));
    ln = {8{32'hA5A5_2000}};
    checkOutput("t5_miss_data", cache_rdata, ln);

    // 6: reset while a drain is in flight
    arb_delay = 3;
    arb_hold  = 1'b1;
    applyStimulus(1'b1, 32'h0000_3000, LINE_D, 20, lat, rc);
    k = 0;
    while (!mem_write && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("t6_drain_started", 256'(mem_write), 256'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_cache_resp", 256'(cache_resp), 256'(0));
    checkOutput("t6_rst_cache_rdata", cache_rdata, 256'(0));
    checkOutput("t6_rst_mem_read", 256'(mem_read), 256'(0));
    checkOutput("t6_rst_mem_write", 256'(mem_write), 256'(0));
    checkOutput("t6_rst_mem_address", 256'(mem_address), 256'(0));
    checkOutput("t6_rst_mem_wdata", mem_wdata, 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    arb_hold = 1'b0;
    snap = mem_write_cycles;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t6_no_write_after_reset", 256'(mem_write_cycles), 256'(snap));
    snap = mem_read_cycles;
    applyStimulus(1'b0, 32'h0000_3000, '0, 50, lat, rc);
    checkOutput("t6_lost_line_misses", 256'(mem_read_cycles > snap), 256'(1));
    ln = {8{32'hA5A5_3000}};
    checkOutput("t6_lost_line_data", cache_rdata, ln);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
